// File: rtl/rr_arb4_reg32_pkg.sv
`default_nettype none
// ============================================================================
// rr_arb4_reg32_pkg : shared widths, select encoding and the 32-bit 4:1 mux
// Revision: 1.0
// ============================================================================
package rr_arb4_reg32_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [NUM_REQ-1:0] req_t;

  // S1:S0 encoding of the operand mux: 00 selects IN0 ... 11 selects IN3
  localparam sel_t SEL_IN0 = 2'b00;
  localparam sel_t SEL_IN1 = 2'b01;
  localparam sel_t SEL_IN2 = 2'b10;
  localparam sel_t SEL_IN3 = 2'b11;

  function automatic word_t mux4(input sel_t sel, input word_t in0, input word_t in1,
                                 input word_t in2, input word_t in3);
    word_t y;
    case (sel)
      SEL_IN0: y = in0;
      SEL_IN1: y = in1;
      SEL_IN2: y = in2;
      default: y = in3;
    endcase
    return y;
  endfunction

  function automatic req_t sel_to_onehot(input sel_t sel);
    req_t oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage : rr_arb4_reg32_pkg
`default_nettype wire

// File: rtl/rr_arb4_reg32_pri_enc4.sv
`default_nettype none
// ============================================================================
// rr_pri_enc4 : rotating priority encoder, first requester at or after rr_ptr
// Revision: 1.0
// ============================================================================
module rr_pri_enc4
  import rr_arb4_reg32_pkg::*;
(
  input  logic [SEL_W-1:0]   rr_ptr,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   win,
  output logic               any_req
);

  sel_t idx;
  logic found;

  always_comb begin
    win     = '0;
    idx     = '0;
    found   = 1'b0;
    any_req = |req;
    // sel_t arithmetic wraps 3->0 naturally
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + sel_t'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule : rr_pri_enc4
`default_nettype wire

// File: rtl/rr_arb4_reg32.sv
`default_nettype none
// ============================================================================
// rr_arb4_reg32 : 4-way round-robin arbiter driving the 32-bit operand mux,
//                 captured into a 1-entry valid/ready output register
// Revision: 1.0
// ============================================================================
module rr_arb4_reg32
  import rr_arb4_reg32_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  data3,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_src,
  input  logic               out_ready
);

  sel_t  rr_ptr;
  sel_t  win;
  logic  any_req;
  logic  load_en;
  logic  grant_ok;
  word_t mux_out;

  rr_pri_enc4 u_pri_enc (
    .rr_ptr  (rr_ptr),
    .req     (req),
    .win     (win),
    .any_req (any_req)
  );

  // Output slot is free when empty or being drained on this same edge
  assign load_en  = ~out_valid | out_ready;
  assign grant_ok = any_req & load_en & ~rst;
  assign gnt      = grant_ok ? sel_to_onehot(win) : '0;
  assign mux_out  = mux4(win, data0, data1, data2, data3);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (grant_ok) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      out_src   <= win;
      rr_ptr    <= win + sel_t'(1);
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule : rr_arb4_reg32
`default_nettype wire

// File: tb/tb_rr_arb4_reg32.sv
`default_nettype none
// ============================================================================
// tb_rr_arb4_reg32 : directed self-checking bench for rr_arb4_reg32
// Revision: 1.0
// ============================================================================
module tb_rr_arb4_reg32;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data0, data1, data2, data3;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int tests    = 0;
  int failures = 0;

  rr_arb4_reg32 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A requester may only drop req after being granted
  logic [3:0] req_q = 4'h0;
  logic [3:0] gnt_q = 4'h0;
  always @(posedge clk) begin
    assert ((req_q & ~gnt_q & ~req) == 4'h0) else begin
      failures++;
      $error("FAIL req_drop: observed %b expected no drop of %b", req, req_q & ~gnt_q);
    end
    req_q = req;
    gnt_q = gnt;
  end

  initial begin
    logic [1:0]  idx;
    logic [31:0] held;

    rst = 1'b1; req = 4'hF; out_ready = 1'b0;
    data0 = 32'h1111_1111; data1 = 32'h2222_2222;
    data2 = 32'h3333_3333; data3 = 32'h4444_4444;

    // Reset held two cycles with all requesting
    step();
    step();
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_src", {30'h0, out_src}, 32'h0);

    // Round robin from ptr 0: grants 0,1,2,3,0,1,2,3; drop each after its 2nd grant
    rst = 1'b0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      idx = 2'(k);
      chk("rr_gnt", {28'h0, gnt}, 32'h1 << idx);
      step();
      chk("rr_valid", {31'h0, out_valid}, 32'h1);
      chk("rr_data", out_data, 32'h1111_1111 * (idx + 1));
      chk("rr_src", {30'h0, out_src}, {30'h0, idx});
      if (k >= 4) req[idx] = 1'b0;
      #1;
    end

    // Idle cycle drains the output register
    chk("idle_gnt", {28'h0, gnt}, 32'h0);
    step();
    chk("idle_valid", {31'h0, out_valid}, 32'h0);
    chk("idle_data_hold", out_data, 32'h4444_4444);

    // Single request from requester 2 (ptr now 0)
    req = 4'b0100; data2 = 32'hDEAD_BEEF;
    #1;
    chk("single_gnt", {28'h0, gnt}, 32'h4);
    step();
    chk("single_valid", {31'h0, out_valid}, 32'h1);
    chk("single_data", out_data, 32'hDEAD_BEEF);
    chk("single_src", {30'h0, out_src}, 32'h2);

    // Wrap: ptr=3, req 3 and 0 -> 3 first, then 0
    req = 4'b1001;
    #1;
    chk("wrap_gnt3", {28'h0, gnt}, 32'h8);
    step();
    chk("wrap_src3", {30'h0, out_src}, 32'h3);
    chk("wrap_data3", out_data, 32'h4444_4444);
    req = 4'b0001;
    #1;
    chk("wrap_gnt0", {28'h0, gnt}, 32'h1);
    step();
    chk("wrap_src0", {30'h0, out_src}, 32'h0);
    chk("wrap_data0", out_data, 32'h1111_1111);

    // Backpressure: 3 stalled cycles, then release
    req = 4'b0010; out_ready = 1'b0;
    held = out_data;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_gnt", {28'h0, gnt}, 32'h0);
      step();
      chk("bp_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_data", out_data, held);
      chk("bp_src", {30'h0, out_src}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_gnt", {28'h0, gnt}, 32'h2);
    step();
    chk("bp_rel_data", out_data, 32'h2222_2222);
    chk("bp_rel_src", {30'h0, out_src}, 32'h1);

    // Reset mid-op: full stalled register, pending req0 (ptr=2)
    req = 4'b0001; out_ready = 1'b0;
    #1;
    chk("mid_stall_gnt", {28'h0, gnt}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", {28'h0, gnt}, 32'h0);
    step();
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    rst = 1'b0; req = 4'b0101;
    #1;
    // ptr reset to 0 makes requester 0 win over 2
    chk("mid_after_gnt", {28'h0, gnt}, 32'h1);
    step();
    chk("mid_after_valid", {31'h0, out_valid}, 32'h1);
    chk("mid_after_data", out_data, 32'h1111_1111);
    req = 4'b0100; out_ready = 1'b1;
    #1;
    chk("mid_next_gnt", {28'h0, gnt}, 32'h4);
    step();
    chk("mid_next_data", out_data, 32'hDEAD_BEEF);
    req = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule : tb_rr_arb4_reg32
`default_nettype wire
